// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and access checks for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halves need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic lsu_illegal(input logic store, input logic [2:0] funct3);
    if (store) begin
      return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    end
    return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
             funct3 == F3_BU || funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane extraction for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

  // Extend the selected lane to 32 bits according to the load width code.
  always_comb begin
    o_load_data = 32'd0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_load_data = i_word;
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = 32'd0;
    endcase
  end

  // Replace only the addressed lane(s) of the old word with the store data.
  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B:    o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      F3_H:    o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      F3_W:    o_store_word = i_wdata;
      default: o_store_word = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out,
  output logic                  mem_we
);

  lsu_state_t            r_state;
  lsu_state_t            w_next;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_data;
  logic [31:0]           r_mem_wdata;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_req_error;
  logic [31:0]           w_word;
  logic [31:0]           w_load_val;
  logic [31:0]           w_store_word;

  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_req_error = lsu_illegal(req_store, req_funct3) ||
                       lsu_misaligned(req_funct3, req_addr[1:0]);

  // During READ the merge works on the live memory word; afterwards on the captured one.
  assign w_word = (r_state == READ) ? mem_data_out : r_data;

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_word       (w_word),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_val),
    .o_store_word (w_store_word)
  );

  assign mem_address = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_data_in = r_mem_wdata;

  // State register; reset drops mem_we immediately because it decodes from this.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing and state-decoded outputs.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_error = 1'b0;
    resp_rdata = 32'd0;
    mem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_error) begin
            w_next = DONE;
          end else if (req_store && req_funct3 == F3_W) begin
            w_next = WRITE;
          end else begin
            w_next = READ;
          end
        end
      end
      READ: begin
        w_next = r_store ? WRITE : DONE;
      end
      WRITE: begin
        mem_we = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_error = r_error;
        resp_rdata = (r_store || r_error) ? 32'd0 : w_load_val;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the request at acceptance and capture read data / merged write word in READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_data      <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_error  <= w_req_error;
        if (req_store && req_funct3 == F3_W) begin
          r_mem_wdata <= req_wdata;
        end
      end
      if (r_state == READ) begin
        r_data <= mem_data_out;
        if (r_store) begin
          r_mem_wdata <= w_store_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_we;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  int n_checks;
  int n_errors;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_we       (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_address[7:2]];

  // Data memory: DUT writes plus bench preload port.
  always @(posedge clk) begin
    if (mem_we) mem[mem_address[7:2]] <= mem_data_in;
    if (poke_en) mem[poke_idx] <= poke_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx = idx[5:0];
    poke_val = val;
    poke_en  = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[idx] = val;
    @(negedge clk);
  endtask

  // Issue one request from IDLE (at a negedge) and check it against the model.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int          idx, nbytes, sh, lat, we_cyc, got_lat, got_we_cyc, we_cnt;
    logic        err, got_err;
    logic [31:0] old_w, new_w, exp_rd, b, mask, got_rd, got_din, got_maddr;

    idx    = int'(a[7:2]);
    old_w  = ref_mem[idx];
    nbytes = 1 << f3[1:0];
    sh     = 8 * int'(a[1:0]);
    if (st) err = (f3 > 3'd2);
    else    err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!err && (int'(a[1:0]) % nbytes) != 0) err = 1'b1;

    exp_rd = 32'd0;
    new_w  = old_w;
    if (!err && !st) begin
      if (f3 == 3'd2) begin
        exp_rd = old_w;
      end else if (f3[1:0] == 2'd0) begin
        b = (old_w >> sh) & 32'hFF;
        exp_rd = (f3 == 3'd0 && b >= 32'd128) ? b - 32'd256 : b;
      end else begin
        b = (old_w >> sh) & 32'hFFFF;
        exp_rd = (f3 == 3'd1 && b >= 32'd32768) ? b - 32'd65536 : b;
      end
    end
    if (!err && st) begin
      if (f3 == 3'd2) begin
        new_w = wd;
      end else begin
        mask  = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
        new_w = (old_w & ~mask) | ((wd << sh) & mask);
      end
    end

    if (err)              begin lat = 1; we_cyc = 0; end
    else if (!st)         begin lat = 2; we_cyc = 0; end
    else if (f3 == 3'd2)  begin lat = 2; we_cyc = 1; end
    else                  begin lat = 3; we_cyc = 2; end

    chk("idle_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    got_lat = 0; got_we_cyc = 0; we_cnt = 0;
    got_rd = 32'd0; got_err = 1'b0; got_din = 32'd0; got_maddr = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      if (got_lat == 0) begin
        @(negedge clk);
        chk("busy_ready", req_ready, 0);
        if (mem_we) begin
          we_cnt++;
          got_we_cyc = k;
          got_din    = mem_data_in;
          got_maddr  = mem_address;
        end
        if (resp_valid) begin
          got_lat = k;
          got_rd  = resp_rdata;
          got_err = resp_error;
        end
      end
    end

    chk("latency", 32'(got_lat), 32'(lat));
    chk("resp_error", got_err, err);
    chk("resp_rdata", got_rd, exp_rd);
    chk("we_count", 32'(we_cnt), (we_cyc == 0) ? 32'd0 : 32'd1);
    if (we_cyc != 0) begin
      chk("we_cycle", 32'(got_we_cyc), 32'(we_cyc));
      chk("we_data", got_din, new_w);
      chk("we_addr", got_maddr, {a[31:2], 2'b00});
    end

    @(negedge clk);
    chk("ready_after", req_ready, 1);
    chk("no_resp_idle", resp_valid, 0);
    chk("mem_word", mem[idx], new_w);
    ref_mem[idx] = new_w;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    poke_en    = 1'b0;
    poke_idx   = 6'd0;
    poke_val   = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_error", resp_error, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_mem_we", mem_we, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 64; i++) poke(i, $urandom);

    poke(4, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);

    poke(4, 32'h80FF1234);
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0);

    poke(8, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h21, 32'h000000AB);
    chk("sb_word", mem[8], 32'h1122AB44);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);

    poke(12, 32'h0);
    do_req(1'b1, 3'b001, 32'h32, 32'h0000CAFE);
    chk("sh_word", mem[12], 32'hCAFE0000);
    do_req(1'b1, 3'b010, 32'h34, 32'h01020304);
    chk("sw_word", mem[13], 32'h01020304);

    do_req(1'b0, 3'b001, 32'h41, 32'h0);
    do_req(1'b0, 3'b010, 32'h42, 32'h0);
    do_req(1'b1, 3'b100, 32'h40, 32'h12345678);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      logic [2:0]  rf;
      logic        rs;
      ra = $urandom;
      rf = 3'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      do_req(rs, rf, ra, $urandom);
    end

    poke(8, 32'h11223344);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h21;
    req_wdata  = 32'h000000AB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_read_no_we", mem_we, 0);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_resp", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_after_resp", resp_valid, 0);
      chk("rst_after_we", mem_we, 0);
    end
    chk("rst_mem_unchanged", mem[8], 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
